// File: rtl/pcie_tx_arb_pkg.sv
// Shared constants and state encoding for the PCIe TX arbiter.
// Optional stats output is enabled with PCIE_TX_ARB_STATS_EN.
package pcie_tx_arb_pkg;

   localparam int TX_DW  = 128;
   localparam int TX_SW  = 16;
   localparam int TX_UW  = 4;
   localparam int STAT_W = 32;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_XFER = 2'd1,
      ARB_CFG  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/pcie_rr_pick.sv
// Combinational round-robin picker: first set request
// searching upward from (last + 1) mod N.
module pcie_rr_pick
   import pcie_tx_arb_pkg::*;
#(
   parameter int N = 2
)(
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic             o_vld,
   output logic [IDX_W-1:0] o_idx
);

   always_comb begin
      o_vld = 1'b0;
      o_idx = '0;
      for (int k = 1; k <= N; k++) begin
         if (!o_vld && i_req[(int'(i_last) + k) % N]) begin
            o_vld = 1'b1;
            o_idx = IDX_W'((int'(i_last) + k) % N);
         end
      end
   end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-level round-robin arbiter onto the PCIe AXI-S TX port.
// Define PCIE_TX_ARB_STATS_EN to add per-requester TLP counters.
module pcie_tx_arbiter
   import pcie_tx_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int BUF_MIN = 2
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ*TX_DW-1:0] req_tdata,
   input  logic [NUM_REQ*TX_SW-1:0] req_tstrb,
   input  logic [NUM_REQ*TX_UW-1:0] req_tuser,
   input  logic [NUM_REQ-1:0]       req_tlast,
   input  logic [NUM_REQ-1:0]       req_tvalid,
   output logic [NUM_REQ-1:0]       req_tready,
   output logic [TX_DW-1:0]         s_axis_tx_tdata,
   output logic [TX_SW-1:0]         s_axis_tx_tstrb,
   output logic [TX_UW-1:0]         s_axis_tx_tuser,
   output logic                     s_axis_tx_tlast,
   output logic                     s_axis_tx_tvalid,
   input  logic                     s_axis_tx_tready,
   input  logic [5:0]               tx_buf_av,
   input  logic                     tx_cfg_req,
   output logic                     tx_cfg_gnt,
   output logic [IDX_W-1:0]         gnt_id,
   output logic                     busy
`ifdef PCIE_TX_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0] stat_tlp_cnt
`endif
);

   localparam logic [5:0]       BUF_MIN_V = 6'(BUF_MIN);
   localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

   arb_state_e       r_state;
   arb_state_e       w_nxt;
   logic [IDX_W-1:0] r_gnt;
   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_vld;
   logic             w_xfer;
   logic             w_grant;
   logic             w_done;
   logic [TX_DW-1:0] w_data;
   logic [TX_SW-1:0] w_strb;
   logic [TX_UW-1:0] w_user;
   logic             w_vld;
   logic             w_last;

   pcie_rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .i_req  (req_tvalid),
      .i_last (r_last),
      .o_vld  (w_pick_vld),
      .o_idx  (w_pick_idx)
   );

   always_comb begin
      w_data = '0;
      w_strb = '0;
      w_user = '0;
      w_vld  = 1'b0;
      w_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gnt == IDX_W'(i)) begin
            w_data = req_tdata[i*TX_DW +: TX_DW];
            w_strb = req_tstrb[i*TX_SW +: TX_SW];
            w_user = req_tuser[i*TX_UW +: TX_UW];
            w_vld  = req_tvalid[i];
            w_last = req_tlast[i];
         end
      end
   end

   assign w_xfer  = (r_state == ARB_XFER);
   assign w_done  = w_xfer & w_vld & s_axis_tx_tready & w_last;
   // Cfg beats requesters; buffers are only checked here.
   assign w_grant = (r_state == ARB_IDLE) & ~tx_cfg_req &
                    w_pick_vld & (tx_buf_av >= BUF_MIN_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (tx_cfg_req) begin
               w_nxt = ARB_CFG;
            end else if (w_grant) begin
               w_nxt = ARB_XFER;
            end
         end
         ARB_XFER: begin
            if (w_done) w_nxt = ARB_IDLE;
         end
         ARB_CFG: begin
            if (!tx_cfg_req) w_nxt = ARB_IDLE;
         end
         default: w_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt  <= '0;
         r_last <= LAST_RST;
      end else begin
         if (w_grant) r_gnt  <= w_pick_idx;
         if (w_done)  r_last <= r_gnt;
      end
   end

   always_comb begin
      req_tready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_xfer && (r_gnt == IDX_W'(i))) begin
            req_tready[i] = s_axis_tx_tready;
         end
      end
   end

   assign s_axis_tx_tdata  = w_xfer ? w_data : '0;
   assign s_axis_tx_tstrb  = w_xfer ? w_strb : '0;
   assign s_axis_tx_tuser  = w_xfer ? w_user : '0;
   assign s_axis_tx_tvalid = w_xfer & w_vld;
   assign s_axis_tx_tlast  = w_xfer & w_last;
   assign tx_cfg_gnt       = (r_state == ARB_CFG) & tx_cfg_req;
   assign gnt_id           = r_gnt;
   assign busy             = (r_state != ARB_IDLE);

`ifdef PCIE_TX_ARB_STATS_EN
   logic [STAT_W-1:0] r_stat [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_done && (r_gnt == IDX_W'(i))) begin
               r_stat[i] <= r_stat[i] + STAT_W'(1);
            end
         end
      end
   end

   always_comb begin
      stat_tlp_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_tlp_cnt[i*STAT_W +: STAT_W] = r_stat[i];
      end
   end
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: vector table, directed corner
// cases and a randomized run against a link-ownership model.
`timescale 1ns/1ps
module tb_pcie_tx_arbiter;

   localparam int N    = 2;
   localparam int BMIN = 2;
   localparam int NV   = 21;
   localparam int NRND = 3000;
   localparam int OWN_NONE = -1;
   localparam int OWN_CFG  = 99;

   localparam logic [127:0] D0 = {4{32'hA0A0_0A0A}};
   localparam logic [127:0] D1 = {4{32'hB1B1_1B1B}};
   localparam logic [15:0]  S0 = 16'h00FF;
   localparam logic [15:0]  S1 = 16'hF0F0;
   localparam logic [3:0]   U0 = 4'h3;
   localparam logic [3:0]   U1 = 4'hC;

   typedef struct {
      logic [1:0] vld;
      logic [1:0] lst;
      logic       rdy;
      logic [5:0] bav;
      logic       cfg;
      logic       busy;
      logic       xfer;
      logic [2:0] gnt;
      logic       sv;
      logic       cg;
      logic [1:0] rr;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N*128-1:0] req_tdata;
   logic [N*16-1:0]  req_tstrb;
   logic [N*4-1:0]   req_tuser;
   logic [N-1:0]   req_tlast;
   logic [N-1:0]   req_tvalid;
   logic [N-1:0]   req_tready;
   logic [127:0]   s_tdata;
   logic [15:0]    s_tstrb;
   logic [3:0]     s_tuser;
   logic           s_tlast;
   logic           s_tvalid;
   logic           s_tready;
   logic [5:0]     buf_av;
   logic           cfg_req;
   logic           cfg_gnt;
   logic [2:0]     gnt_id;
   logic           busy;
`ifdef PCIE_TX_ARB_STATS_EN
   logic [N*32-1:0] stat_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pcie_tx_arbiter #(
      .NUM_REQ (N),
      .BUF_MIN (BMIN)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_tdata        (req_tdata),
      .req_tstrb        (req_tstrb),
      .req_tuser        (req_tuser),
      .req_tlast        (req_tlast),
      .req_tvalid       (req_tvalid),
      .req_tready       (req_tready),
      .s_axis_tx_tdata  (s_tdata),
      .s_axis_tx_tstrb  (s_tstrb),
      .s_axis_tx_tuser  (s_tuser),
      .s_axis_tx_tlast  (s_tlast),
      .s_axis_tx_tvalid (s_tvalid),
      .s_axis_tx_tready (s_tready),
      .tx_buf_av        (buf_av),
      .tx_cfg_req       (cfg_req),
      .tx_cfg_gnt       (cfg_gnt),
      .gnt_id           (gnt_id),
      .busy             (busy)
`ifdef PCIE_TX_ARB_STATS_EN
      ,
      .stat_tlp_cnt     (stat_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ctl_vec(input logic gmask);
      return {7'd0, req_tready, s_tvalid, s_tlast, cfg_gnt, busy,
              gmask ? gnt_id : 3'd0};
   endfunction

   function automatic vec_t mk(input int vld, lst, rdy, bav, cfg,
                               bz, x, g, sv, cg, rr);
      vec_t v;
      v.vld  = 2'(vld);
      v.lst  = 2'(lst);
      v.rdy  = 1'(rdy);
      v.bav  = 6'(bav);
      v.cfg  = 1'(cfg);
      v.busy = 1'(bz);
      v.xfer = 1'(x);
      v.gnt  = 3'(g);
      v.sv   = 1'(sv);
      v.cg   = 1'(cg);
      v.rr   = 2'(rr);
      return v;
   endfunction

   function automatic logic [127:0] beat_data(input int b);
      return {4{32'hC0DE_0000 + 32'(b)}};
   endfunction

   task automatic set_idle();
      req_tdata  = '0;
      req_tstrb  = '0;
      req_tuser  = '0;
      req_tlast  = '0;
      req_tvalid = '0;
      s_tready   = 1'b1;
      buf_av     = 6'd10;
      cfg_req    = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, ctl_vec(1'b1), '0);
      chk({nm, "_data"}, s_tdata, '0);
      chk({nm, "_side"}, {s_tstrb, s_tuser}, '0);
`ifdef PCIE_TX_ARB_STATS_EN
      chk({nm, "_stats"}, stat_cnt, '0);
`endif
   endtask

   task automatic do_reset(input logic ck);
      rst_n = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1;
      if (ck) chk_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[NV];
      vec_t v;
      logic [15:0]  e_ctl;
      logic [127:0] e_d;
      logic [19:0]  e_side;
      logic [2:0]   gseq[4];
      logic         first, mx;
      int b, xf, lastc, ntlp, own, ml, c;
      int rem[N];
      int done[N];
      int mcnt[N];

      tbl[0]  = mk(1, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 1, 10, 0, 1, 1, 0, 1, 0, 1);
      tbl[2]  = mk(1, 0, 1, 10, 0, 1, 1, 0, 1, 0, 1);
      tbl[3]  = mk(1, 1, 1, 10, 0, 1, 1, 0, 1, 0, 1);
      tbl[4]  = mk(0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(1, 0, 1,  2, 0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = mk(1, 0, 1,  0, 0, 1, 1, 0, 1, 0, 1);
      tbl[9]  = mk(1, 1, 0,  0, 0, 1, 1, 0, 1, 0, 0);
      tbl[10] = mk(1, 1, 1,  0, 0, 1, 1, 0, 1, 0, 1);
      tbl[11] = mk(0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      tbl[12] = mk(3, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(3, 0, 1, 10, 1, 1, 1, 1, 1, 0, 2);
      tbl[14] = mk(3, 2, 1, 10, 1, 1, 1, 1, 1, 0, 2);
      tbl[15] = mk(1, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 1, 10, 1, 1, 0, 0, 0, 1, 0);
      tbl[17] = mk(1, 0, 1, 10, 0, 1, 0, 0, 0, 0, 0);
      tbl[18] = mk(1, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      tbl[19] = mk(1, 1, 1, 10, 0, 1, 1, 0, 1, 0, 1);
      tbl[20] = mk(0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0);

      do_reset(1'b1);

      // vector table
      req_tdata = {D1, D0};
      req_tstrb = {S1, S0};
      req_tuser = {U1, U0};
      for (int i = 0; i < NV; i++) begin
         v = tbl[i];
         req_tvalid = v.vld;
         req_tlast  = v.lst;
         s_tready   = v.rdy;
         buf_av     = v.bav;
         cfg_req    = v.cfg;
         @(negedge clk);
         e_ctl = {7'd0, v.rr, v.sv, v.xfer & v.lst[v.gnt[0]],
                  v.cg, v.busy, v.xfer ? v.gnt : 3'd0};
         e_d    = v.xfer ? (v.gnt == 3'd0 ? D0 : D1) : '0;
         e_side = v.xfer ? (v.gnt == 3'd0 ? {S0, U0} : {S1, U1}) : '0;
         chk($sformatf("vec%0d_ctl", i), ctl_vec(v.xfer), e_ctl);
         chk($sformatf("vec%0d_data", i), s_tdata, e_d);
         chk($sformatf("vec%0d_side", i), {s_tstrb, s_tuser}, e_side);
         @(posedge clk);
         #1;
      end

      // 4-beat TLP with core tready toggling
      set_idle();
      b  = 0;
      xf = 0;
      for (int cyc = 0; cyc < 30 && b < 4; cyc++) begin
         req_tvalid = 2'b01;
         req_tlast  = {1'b0, b == 3};
         req_tdata[127:0] = beat_data(b);
         s_tready   = cyc[0];
         @(negedge clk);
         if (s_tvalid) chk("toggle_data", s_tdata, beat_data(b));
         if (s_tvalid && s_tready) xf++;
         if (req_tvalid[0] && req_tready[0]) b++;
         @(posedge clk);
         #1;
      end
      set_idle();
      chk("toggle_xfers", xf, 4);
      chk("toggle_beats", b, 4);
      @(negedge clk);
      chk("toggle_idle", busy, 1'b0);
      @(posedge clk);
      #1;

      // both requesters streaming 2-beat TLPs
      do_reset(1'b0);
      rem[0] = 0;
      rem[1] = 0;
      ntlp   = 0;
      lastc  = 0;
      first  = 1'b1;
      for (int i = 0; i < 4; i++) gseq[i] = 3'd7;
      for (int cyc = 0; cyc < 40 && ntlp < 4; cyc++) begin
         req_tvalid = 2'b11;
         req_tlast  = {rem[1] == 1, rem[0] == 1};
         req_tdata  = {D1, D0};
         s_tready   = 1'b1;
         @(negedge clk);
         if (s_tvalid && s_tready) begin
            if (first) begin
               gseq[ntlp] = gnt_id;
               if (ntlp > 0) chk("rr_bubble", cyc - lastc - 1, 1);
            end
            first = s_tlast;
            if (s_tlast) begin
               ntlp++;
               lastc = cyc;
            end
         end
         for (int r = 0; r < N; r++)
            if (req_tready[r]) rem[r] = 1 - rem[r];
         @(posedge clk);
         #1;
      end
      set_idle();
      chk("rr_count", ntlp, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr_gnt%0d", i), gseq[i], 3'(i % 2));

      // reset asserted in the middle of a 4-beat TLP
      @(posedge clk);
      #1;
      b = 0;
      for (int cyc = 0; cyc < 20 && b < 2; cyc++) begin
         req_tvalid = 2'b01;
         req_tlast  = 2'b00;
         req_tdata[127:0] = beat_data(b);
         @(negedge clk);
         if (req_tready[0]) b++;
         @(posedge clk);
         #1;
      end
      req_tvalid = 2'b11;
      req_tdata  = {D1, beat_data(2)};
      req_tstrb  = {S1, S0};
      req_tuser  = {U1, U0};
      #1;
      chk("midrst_before", s_tvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 1'b1);
      chk("post_rst_gnt", gnt_id, 3'd0);

      // randomized traffic against the ownership model
      do_reset(1'b0);
      own = OWN_NONE;
      ml  = N - 1;
      c   = 0;
      for (int r = 0; r < N; r++) begin
         rem[r]  = 0;
         done[r] = 0;
         mcnt[r] = 0;
      end
      for (int cyc = 0; cyc < NRND; cyc++) begin
         for (int r = 0; r < N; r++) begin
            if (rem[r] == 0 && $urandom_range(0, 1) == 1)
               rem[r] = $urandom_range(1, 4);
            req_tvalid[r] = (rem[r] != 0) && ($urandom_range(0, 3) != 0);
            req_tlast[r]  = (rem[r] == 1);
            req_tdata[r*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
            req_tstrb[r*16 +: 16]   = 16'($urandom);
            req_tuser[r*4 +: 4]     = 4'($urandom);
         end
         if (cfg_req) cfg_req = ($urandom_range(0, 4) != 0);
         else         cfg_req = ($urandom_range(0, 29) == 0);
         buf_av   = 6'($urandom_range(0, 5));
         s_tready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         mx = (own >= 0) && (own < N);
         if (mx) begin
            e_ctl  = {7'd0, s_tready ? 2'(1 << own) : 2'b00,
                      req_tvalid[own], req_tlast[own], 1'b0, 1'b1,
                      3'(own)};
            e_d    = req_tdata[own*128 +: 128];
            e_side = {req_tstrb[own*16 +: 16], req_tuser[own*4 +: 4]};
         end else begin
            e_ctl  = {7'd0, 2'b00, 1'b0, 1'b0,
                      (own == OWN_CFG) && cfg_req, own == OWN_CFG, 3'd0};
            e_d    = '0;
            e_side = '0;
         end
         chk("rnd_ctl", ctl_vec(mx), e_ctl);
         chk("rnd_data", s_tdata, e_d);
         chk("rnd_side", {s_tstrb, s_tuser}, e_side);
         if (own == OWN_NONE) begin
            if (cfg_req) begin
               own = OWN_CFG;
            end else if (req_tvalid != '0 && buf_av >= BMIN) begin
               for (int k = 1; k <= N && own == OWN_NONE; k++)
                  if (req_tvalid[(ml + k) % N]) own = (ml + k) % N;
            end
         end else if (own == OWN_CFG) begin
            if (!cfg_req) own = OWN_NONE;
         end else if (req_tvalid[own] && s_tready && req_tlast[own]) begin
            mcnt[own]++;
            ml  = own;
            own = OWN_NONE;
         end
         for (int r = 0; r < N; r++) begin
            if (req_tvalid[r] && req_tready[r]) begin
               if (rem[r] == 1) done[r]++;
               rem[r]--;
            end
         end
         @(posedge clk);
         #1;
      end
      for (int r = 0; r < N; r++)
         chk($sformatf("rnd_tlps%0d", r), done[r], mcnt[r]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
